// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - ball motion, wall/paddle bounces and point detection on a 64x64 field
// Optional macro SPEEDUP_EN: the step period shortens as paddle hits accumulate in a rally.
module pong_ball_engine #(
  parameter int TICK_DIV   = 8,
  parameter int PADDLE_H   = 8,
  parameter int HOLD_TICKS = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       enable,
  input  logic       serve,
  input  logic       serve_dx,
  input  logic       serve_dy,
  input  logic [5:0] paddle_a_y,
  input  logic [5:0] paddle_b_y,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic       point_a,
  output logic       point_b,
  output logic       in_play,
  output logic [7:0] hit_count
);

  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DIV_BASE  = DW'(TICK_DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SCORED} state_t;

  state_t        state;
  logic          dx;
  logic          dy;
  logic [DW-1:0] cnt;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_next;
  logic [HW-1:0] hold;
  logic          step;
  logic          hit_a;
  logic          hit_b;
  logic [5:0]    y_next;
  logic          dy_next;
  logic [7:0]    hits_inc;

  // Paddle span is clipped at the bottom wall so a low paddle still covers row 63.
  function automatic logic paddle_hit(input logic [5:0] top, input logic [5:0] y);
    logic [6:0] bot;
    bot = {1'b0, top} + 7'(PADDLE_H - 1);
    if (bot > 7'd63) bot = 7'd63;
    return (y >= top) && ({1'b0, y} <= bot);
  endfunction

  assign hit_a    = paddle_hit(paddle_a_y, ball_y);
  assign hit_b    = paddle_hit(paddle_b_y, ball_y);
  assign step     = enable && (state != S_IDLE) && (cnt == div_q - DW'(1));
  assign hits_inc = (hit_count == 8'd255) ? hit_count : hit_count + 8'd1;

  always_comb begin
    y_next  = ball_y;
    dy_next = dy;
    if (dy) begin
      if (ball_y == 6'd63) begin
        y_next  = 6'd62;
        dy_next = 1'b0;
      end else begin
        y_next = ball_y + 6'd1;
      end
    end else begin
      if (ball_y == 6'd0) begin
        y_next  = 6'd1;
        dy_next = 1'b1;
      end else begin
        y_next = ball_y - 6'd1;
      end
    end
  end

`ifdef SPEEDUP_EN
  logic [7:0] hits_after;

  // Period for the next step uses the hit count including a hit made on this step.
  always_comb begin
    hits_after = hit_count;
    if (state == S_PLAY &&
        ((!dx && ball_x == 6'd1 && hit_a) || (dx && ball_x == 6'd62 && hit_b)))
      hits_after = hits_inc;
    if (hits_after >= 8'd8)
      div_next = DIV_BASE >> 2;
    else if (hits_after >= 8'd4)
      div_next = DIV_BASE >> 1;
    else
      div_next = DIV_BASE;
  end
`else
  assign div_next = DIV_BASE;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= S_IDLE;
      ball_x    <= 6'd32;
      ball_y    <= 6'd32;
      dx        <= 1'b0;
      dy        <= 1'b0;
      cnt       <= '0;
      div_q     <= DIV_BASE;
      hold      <= '0;
      hit_count <= 8'd0;
      point_a   <= 1'b0;
      point_b   <= 1'b0;
      in_play   <= 1'b0;
    end else begin
      point_a <= 1'b0;
      point_b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && serve) begin
            dx        <= serve_dx;
            dy        <= serve_dy;
            hit_count <= 8'd0;
            cnt       <= '0;
            div_q     <= DIV_BASE;
            state     <= S_PLAY;
            in_play   <= 1'b1;
          end
        end
        S_PLAY: begin
          if (step) begin
            cnt    <= '0;
            div_q  <= div_next;
            ball_y <= y_next;
            dy     <= dy_next;
            if (!dx && ball_x == 6'd1) begin
              if (hit_a) begin
                dx        <= 1'b1;
                ball_x    <= 6'd2;
                hit_count <= hits_inc;
              end else begin
                ball_x  <= 6'd0;
                point_b <= 1'b1;
                hold    <= '0;
                state   <= S_SCORED;
                in_play <= 1'b0;
              end
            end else if (dx && ball_x == 6'd62) begin
              if (hit_b) begin
                dx        <= 1'b0;
                ball_x    <= 6'd61;
                hit_count <= hits_inc;
              end else begin
                ball_x  <= 6'd63;
                point_a <= 1'b1;
                hold    <= '0;
                state   <= S_SCORED;
                in_play <= 1'b0;
              end
            end else begin
              ball_x <= dx ? ball_x + 6'd1 : ball_x - 6'd1;
            end
          end else if (enable) begin
            cnt <= cnt + DW'(1);
          end
        end
        S_SCORED: begin
          if (step) begin
            cnt   <= '0;
            div_q <= div_next;
            if (hold == HOLD_LAST) begin
              ball_x <= 6'd32;
              ball_y <= 6'd32;
              state  <= S_IDLE;
            end else begin
              hold <= hold + HW'(1);
            end
          end else if (enable) begin
            cnt <= cnt + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - vector table, hand sequences and randomized run against a step-level model
module tb_pong_ball_engine;

  localparam int TD = 4;
  localparam int PH = 8;
  localparam int HT = 4;

  logic       clk = 1'b0;
  logic       rst, en, srv, sdx, sdy;
  logic [5:0] pay, pby;
  logic [5:0] ball_x, ball_y;
  logic       point_a, point_b, in_play;
  logic [7:0] hit_count;

  pong_ball_engine #(.TICK_DIV(TD), .PADDLE_H(PH), .HOLD_TICKS(HT)) dut (
    .clk_clk(clk), .reset_reset(rst), .enable(en), .serve(srv),
    .serve_dx(sdx), .serve_dy(sdy), .paddle_a_y(pay), .paddle_b_y(pby),
    .ball_x(ball_x), .ball_y(ball_y), .point_a(point_a), .point_b(point_b),
    .in_play(in_play), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Model: 0 = idle, 1 = play, 2 = scored; the ball moves one cell per axis per step.
  int m_state, m_x, m_y, m_dx, m_dy, m_phase, m_div, m_hits, m_hold;
  bit m_pa, m_pb;

  function automatic bit in_paddle(input int top, input int y);
    int bot;
    bot = top + PH - 1;
    if (bot > 63) bot = 63;
    return (y >= top) && (y <= bot);
  endfunction

  task automatic model_step();
    int ny, nx;
    if (m_state == 1) begin
      ny = m_y + (m_dy ? 1 : -1);
      if (ny > 63) begin ny = 62; m_dy = 0; end
      else if (ny < 0) begin ny = 1; m_dy = 1; end
      nx = m_x + (m_dx ? 1 : -1);
      if (nx == 0) begin
        if (in_paddle(pay, m_y)) begin nx = 2; m_dx = 1; m_hits = (m_hits < 255) ? m_hits + 1 : 255; end
        else begin m_pb = 1; m_state = 2; m_hold = 0; end
      end else if (nx == 63) begin
        if (in_paddle(pby, m_y)) begin nx = 61; m_dx = 0; m_hits = (m_hits < 255) ? m_hits + 1 : 255; end
        else begin m_pa = 1; m_state = 2; m_hold = 0; end
      end
      m_x = nx;
      m_y = ny;
    end else begin
      m_hold++;
      if (m_hold == HT) begin m_state = 0; m_x = 32; m_y = 32; end
    end
`ifdef SPEEDUP_EN
    m_div = TD >> ((m_hits / 4 > 2) ? 2 : m_hits / 4);
`endif
  endtask

  task automatic model_clk();
    if (rst) begin
      m_state = 0; m_x = 32; m_y = 32; m_dx = 0; m_dy = 0;
      m_phase = 0; m_div = TD; m_hits = 0; m_hold = 0; m_pa = 0; m_pb = 0;
      return;
    end
    m_pa = 0;
    m_pb = 0;
    if (m_state == 0) begin
      if (en && srv) begin
        m_dx = sdx; m_dy = sdy; m_hits = 0; m_phase = 0; m_div = TD; m_state = 1;
      end
    end else if (en) begin
      m_phase++;
      if (m_phase == m_div) begin
        m_phase = 0;
        model_step();
      end
    end
  endtask

  task automatic cyc();
    logic [28:0] exp_v, act_v;
    @(posedge clk);
    model_clk();
    #1;
    exp_v = {6'(m_x), 6'(m_y), m_pa, m_pb, (m_state == 1), 8'(m_hits)};
    act_v = {ball_x, ball_y, point_a, point_b, in_play, hit_count};
    chk("scoreboard", int'(act_v), int'(exp_v));
    if (point_a && point_b) chk("points_exclusive", 1, 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic do_serve(input bit dxv, input bit dyv);
    srv = 1'b1; sdx = dxv; sdy = dyv; cyc(); srv = 1'b0;
  endtask

  typedef struct {
    bit dx; bit dy; int pa; int pb; int n;
    int ex; int ey; int eh; int eplay;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; en = 1'b1; srv = 1'b0; sdx = 1'b0; sdy = 1'b0; pay = 6'd0; pby = 6'd0;

    tbl[0]  = '{1, 1, 0,  0,  1, 33, 33, 0, 1};
    tbl[1]  = '{1, 1, 0,  0,  2, 34, 34, 0, 1};
    tbl[2]  = '{0, 0, 0,  0,  3, 29, 29, 0, 1};
    tbl[3]  = '{1, 0, 0,  0,  5, 37, 27, 0, 1};
    tbl[4]  = '{1, 1, 0, 60, 31, 61, 63, 1, 1};
    tbl[5]  = '{1, 1, 0, 60, 32, 60, 62, 1, 1};
    tbl[6]  = '{1, 1, 0,  0, 31, 63, 63, 0, 0};
    tbl[7]  = '{0, 0, 0,  0, 32,  2,  0, 1, 1};
    tbl[8]  = '{0, 0, 40, 0, 32,  0,  0, 0, 0};
    tbl[9]  = '{0, 1, 56, 0, 32,  2, 62, 1, 1};
    tbl[10] = '{1, 1, 0, 63, 31, 63, 63, 0, 0};

    do_reset();
    chk("reset_x", ball_x, 32);
    chk("reset_y", ball_y, 32);
    chk("reset_in_play", in_play, 0);
    chk("reset_hits", hit_count, 0);
    chk("reset_points", {point_a, point_b}, 0);

    for (int t = 0; t < 11; t++) begin
      do_reset();
      pay = 6'(tbl[t].pa);
      pby = 6'(tbl[t].pb);
      do_serve(tbl[t].dx, tbl[t].dy);
      cycles(tbl[t].n * TD);
      chk($sformatf("vec%0d_x", t), ball_x, tbl[t].ex);
      chk($sformatf("vec%0d_y", t), ball_y, tbl[t].ey);
      chk($sformatf("vec%0d_hits", t), hit_count, tbl[t].eh);
      chk($sformatf("vec%0d_in_play", t), in_play, tbl[t].eplay);
    end

    // Miss at paddle A: one-cycle point_b, goal hold, then re-centre and accept a new serve.
    do_reset();
    pay = 6'd40;
    do_serve(0, 0);
    cycles(32 * TD);
    chk("miss_point_b", point_b, 1);
    chk("miss_point_a", point_a, 0);
    cyc();
    chk("miss_pulse_len", point_b, 0);
    cycles(HT * TD - 2);
    chk("hold_x", ball_x, 0);
    cyc();
    chk("recentre_x", ball_x, 32);
    chk("recentre_y", ball_y, 32);
    do_serve(1, 1);
    chk("reserve_in_play", in_play, 1);
    chk("reserve_hits", hit_count, 0);

    // Pause mid-period, serve during play, reset mid-rally.
    do_reset();
    pay = 6'd0; pby = 6'd0;
    do_serve(1, 1);
    cycles(3 * TD + 2);
    en = 1'b0;
    srv = 1'b1; sdx = 1'b0; sdy = 1'b0;
    cycles(20);
    srv = 1'b0;
    chk("pause_x", ball_x, 35);
    chk("pause_y", ball_y, 35);
    en = 1'b1;
    cycles(TD - 3);
    chk("resume_hold_x", ball_x, 35);
    cyc();
    chk("resume_step_x", ball_x, 36);
    do_serve(0, 0);
    cycles(TD - 1);
    chk("serve_ignored_x", ball_x, 37);
    chk("serve_ignored_y", ball_y, 37);
    chk("serve_ignored_play", in_play, 1);
    cycles(2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midreset_x", ball_x, 32);
    chk("midreset_y", ball_y, 32);
    chk("midreset_in_play", in_play, 0);
    chk("midreset_points", {point_a, point_b}, 0);

    // Randomized rallies; paddles are often steered near the model's ball row.
    for (int i = 0; i < 15000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      en  = ($urandom_range(0, 9) != 0);
      srv = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      sdx = $urandom_range(0, 1);
      sdy = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        int a, b;
        a = m_y - int'($urandom_range(0, 9));
        b = m_y - int'($urandom_range(0, 9));
        pay = (a < 0) ? 6'd0 : 6'(a);
        pby = (b < 0) ? 6'd0 : 6'(b);
        if ($urandom_range(0, 3) == 0) pay = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) pby = 6'($urandom_range(0, 63));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Ball-physics stage of the ping-pong game. Moves a ball on a 64x64 field, bounces it off the top/bottom walls and both paddles, and flags points. Sits directly upstream of the QSYS system: ball_x/ball_y drive the ball_x/ball_y PIO inputs, and point_a/point_b are read by the CPU, which owns score_a/score_b.

Parameters:
TICK_DIV, 8, clocks per ball step (>=4; must be a multiple of 4 when SPEEDUP_EN is defined)
PADDLE_H, 8, paddle height in field rows (1..32)
HOLD_TICKS, 16, ball steps the ball stays in the goal after a point before re-centring (>=1)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
enable  in  1  1 = run, 0 = pause (tick counter frozen, all state held)
serve  in  1  one-cycle pulse; launches the ball from IDLE
serve_dx  in  1  initial x direction on serve (1 = right / toward B, 0 = left / toward A)
serve_dy  in  1  initial y direction on serve (1 = down / increasing y, 0 = up)
paddle_a_y  in  6  top row of paddle A (column x=1)
paddle_b_y  in  6  top row of paddle B (column x=62)
ball_x  out  6  ball column
ball_y  out  6  ball row
point_a  out  1  one-cycle pulse: player A scored (ball entered x=63)
point_b  out  1  one-cycle pulse: player B scored (ball entered x=0)
in_play  out  1  1 while state = PLAY
hit_count  out  8  paddle hits in the current rally, saturating at 255

Behaviour:
- Reset: state=IDLE, ball_x=32, ball_y=32, dx=0, dy=0, tick counter=0, hit_count=0, point_a=point_b=0, in_play=0.
- Tick: counter counts 0..DIV-1 while enable=1 and state is PLAY or SCORED. step=1 in the cycle the counter equals DIV-1, then the counter wraps to 0. DIV=TICK_DIV unless SPEEDUP_EN is defined. With enable=0 the counter holds and step=0.
- IDLE:
  - Ball held at (32,32).
  - When serve=1 and enable=1: dx<=serve_dx, dy<=serve_dy, hit_count<=0, counter<=0, go to PLAY. in_play=1 from the next cycle.
  - serve is ignored in every other state and while enable=0.
- PLAY, on each step, the y and x axes are evaluated independently in the same step:
  - Y axis: if dy=1 and y=63, then dy<=0 and y<=62. If dy=0 and y=0, then dy<=1 and y<=1. Otherwise y<=y±1.
  - Paddle A hit test: ball_y in [paddle_a_y, paddle_a_y+PADDLE_H-1]. The sum is computed 7 bits wide and clipped to 63. The test uses ball_y before this step's update.
  - Paddle B hit test: same as A, using paddle_b_y.
  - X axis: if dx=0 and x=1 with a paddle A hit, then dx<=1, x<=2, hit_count++. If dx=0 and x=1 without a hit, then x<=0, point_b pulses for one cycle, go to SCORED.
  - Mirror at x=62 for paddle B: hit gives dx<=0, x<=61, hit_count++; miss gives x<=63, point_a pulses, go to SCORED.
  - Otherwise x<=x±1.
- SCORED:
  - Ball frozen at the goal column.
  - Hold count increments on each step. After HOLD_TICKS steps: ball<=(32,32), go to IDLE. hit_count is held until the next serve.
- Latency: position outputs are registered and update in the cycle after step. point pulses are asserted in the same cycle as the goal position.
- Reset mid-operation overrides everything: no point pulse is emitted and the rally is lost.
- point_a and point_b are never asserted together.

Optional Feature:
SPEEDUP_EN
- Defined: DIV = TICK_DIV >> min(hit_count/4, 2), giving TICK_DIV, TICK_DIV/2 or TICK_DIV/4. DIV is re-evaluated only when the counter wraps, so a step period is never truncated.
- Undefined: DIV is fixed at TICK_DIV; hit_count is still reported but has no effect on speed.

Test Plan:
1. TICK_DIV=4, reset, serve with dx=1, dy=1 -> in_play=1; ball advances (33,33), (34,34)... one step every 4 clocks; no point pulse.
2. Wall bounce: ball at y=62 moving down, step, step -> y=63 then y=62, dy=0; x keeps advancing.
3. Paddle A hit: paddle_a_y=10, ball arrives at x=1, y=12, dx=0 -> next step x=2, dx=1, hit_count=1. Repeat with paddle_a_y=40 -> x=0, point_b high for exactly 1 clock, then HOLD_TICKS steps later ball at (32,32) and state IDLE.
4. Corner: ball at (62,63) with dx=1, dy=1, paddle_b_y=56 (hit) -> single step gives (61,62), dx=0, dy=0, hit_count++. Also paddle_b_y=60 with PADDLE_H=8 -> clip at 63 and still a hit.
5. enable=0 for 20 clocks mid-rally -> ball_x/ball_y/counter unchanged; serve pulse during PLAY -> ignored. reset_reset asserted mid-rally -> next cycle (32,32), IDLE, no point pulse.
6. SPEEDUP_EN defined, TICK_DIV=8: after 4 hits the step period is 4 clocks, after 8 hits it is 2 clocks, after 12 hits it is still 2 clocks.
